// File: rtl/psum_drain_784x64_if.sv
// psum_drain_784x64_if: valid/ready word stream carrying one drained lane per transfer
interface psum_drain_784x64_if #(
  parameter int DW = 16,
  parameter int IW = 6
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic [IW-1:0] idx;
  logic          last;
  modport master (output valid, data, idx, last, input ready);
  modport slave (input valid, data, idx, last, output ready);
endinterface

// File: rtl/psum_drain_784x64.sv
// psum_drain_784x64: snapshot the PE-array psum bus on a finish edge and stream its lanes out with optional ReLU
module psum_drain_784x64 #(
  parameter int N_OUT = 64,
  parameter int DW    = 16,
  parameter int RELU  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   finish,
  input  logic [N_OUT*DW-1:0]    psum,
  psum_drain_784x64_if.master    stream,
  output logic                   busy,
  output logic                   overrun
);
  localparam int IW = $clog2(N_OUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t              state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [N_OUT*DW-1:0] snap, snap_nxt;
  logic                finish_d, overrun_nxt, last, last_nxt;
  logic                start, xfer;
  logic [DW-1:0]       word;
  assign start = finish & ~finish_d;
  assign xfer  = (state == DRAIN) & stream.ready;
  assign word  = snap[idx*DW +: DW];
  assign busy  = state == DRAIN;
  assign stream.valid = state == DRAIN;
  assign stream.idx   = idx;
  assign stream.last  = last;
  assign stream.data  = (state == DRAIN && !(RELU != 0 && word[DW-1])) ? word : '0;
  // A start that lands on the final transfer re-arms the drain with no bubble; any other start while draining is dropped and flagged
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    snap_nxt    = snap;
    overrun_nxt = overrun;
    if (state == IDLE) begin
      if (start) begin
        state_nxt = DRAIN;
        idx_nxt   = '0;
        snap_nxt  = psum;
      end
    end else if (xfer && idx == LAST_IDX) begin
      idx_nxt   = '0;
      state_nxt = start ? DRAIN : IDLE;
      snap_nxt  = start ? psum : snap;
    end else begin
      idx_nxt     = xfer ? idx + 1'b1 : idx;
      overrun_nxt = overrun | start;
    end
    last_nxt = (state_nxt == DRAIN) && (idx_nxt == LAST_IDX);
  end
  // State, snapshot and flag registers; reset aborts any drain in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      snap     <= '0;
      finish_d <= 1'b0;
      overrun  <= 1'b0;
      last     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      snap     <= snap_nxt;
      finish_d <= finish;
      overrun  <= overrun_nxt;
      last     <= last_nxt;
    end
  end
endmodule
